// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants, state encodings and frame bundle
// for the multiplexed 7-segment display blocks.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } frame_t;

  function automatic logic [7:0] an_onehot(
    input logic [2:0] i
  );
    return ~(8'h01 << i);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex7seg_decode.sv
// Hex nibble to active-low 7-segment pattern.
// Purely combinational, shared by display blocks.
module hex7seg_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit common-anode scan driver with
// double-buffered frame data and inter-digit blanking.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIG   = 8,
  parameter int BLANK_CYC = 4
) (
  input  logic        I_CLK,
  input  logic        rst_n,
  input  logic        I_SCAN,
  input  logic [31:0] I_DATA,
  input  logic [7:0]  I_DP,
  input  logic [7:0]  I_DIG_EN,
  input  logic        I_LOAD,
  output logic [7:0]  O_AN,
  output logic [6:0]  O_SEG,
  output logic        O_DP,
  output logic [2:0]  O_IDX,
  output logic        O_FRAME
);

  localparam int CW =
    (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CW-1:0] BLK_LAST =
    CW'(BLANK_CYC - 1);
  localparam logic [2:0] IDX_LAST =
    3'(NUM_DIG - 1);

  logic        s1, s2, s3;
  logic        scan_rise;

  scan_state_e state_q, state_d;
  logic [CW-1:0] blk_q, blk_d;
  logic [2:0]  idx_q, idx_d;
  frame_t      pend_q, pend_d;
  frame_t      act_q, act_d;
  frame_t      in_frame;

  logic [7:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;
  logic        frame_d;

  logic [3:0]  nib;
  logic [6:0]  dec_seg;
  logic        dig_en;
  logic [7:0]  drv_an;
  logic [6:0]  drv_seg;
  logic        drv_dp;

  // Two-flop synchroniser plus history flop for edge detect
  always_ff @(posedge I_CLK) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= I_SCAN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign scan_rise = s2 & ~s3;

  assign in_frame = '{
    data: I_DATA,
    dp:   I_DP,
    en:   I_DIG_EN
  };

  assign nib    = act_q.data[{idx_q, 2'b00} +: 4];
  assign dig_en = act_q.en[idx_q];

  hex7seg_decode u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  assign drv_an  = dig_en ? an_onehot(idx_q) : AN_OFF;
  assign drv_seg = dig_en ? dec_seg : SEG_OFF;
  assign drv_dp  = dig_en ? ~act_q.dp[idx_q] : 1'b1;

  // Next state, counters, buffers and output values
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    pend_d  = I_LOAD ? in_frame : pend_q;
    act_d   = act_q;
    an_d    = O_AN;
    seg_d   = O_SEG;
    dp_d    = O_DP;
    frame_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // First edge starts frame at digit 0;
        // load active so it shows pending data.
        if (scan_rise) begin
          state_d = ST_BLANK;
          blk_d   = '0;
          act_d   = pend_d;
          an_d    = AN_OFF;
          seg_d   = SEG_OFF;
          dp_d    = 1'b1;
        end
      end
      ST_BLANK: begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (blk_q == BLK_LAST) begin
          state_d = ST_DRIVE;
          an_d    = drv_an;
          seg_d   = drv_seg;
          dp_d    = drv_dp;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        an_d  = drv_an;
        seg_d = drv_seg;
        dp_d  = drv_dp;
        if (scan_rise) begin
          state_d = ST_BLANK;
          blk_d   = '0;
          an_d    = AN_OFF;
          seg_d   = SEG_OFF;
          dp_d    = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = 3'd0;
            act_d   = pend_d;
            frame_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
      end
    endcase
  end

  // State, counters, buffers and registered outputs
  always_ff @(posedge I_CLK) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      idx_q   <= 3'd0;
      pend_q  <= '0;
      act_q   <= '0;
      O_AN    <= AN_OFF;
      O_SEG   <= SEG_OFF;
      O_DP    <= 1'b1;
      O_FRAME <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      O_AN    <= an_d;
      O_SEG   <= seg_d;
      O_DP    <= dp_d;
      O_FRAME <= frame_d;
    end
  end

  assign O_IDX = idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: 8-digit and
// 5-digit instances share stimulus.
module tb_seg7_scan_driver;

  localparam int BLANK_CYC = 4;

  logic        I_CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        I_SCAN = 1'b0;
  logic [31:0] I_DATA = '0;
  logic [7:0]  I_DP = '0;
  logic [7:0]  I_DIG_EN = '0;
  logic        I_LOAD = 1'b0;

  logic [7:0]  O_AN, an5;
  logic [6:0]  O_SEG, seg5;
  logic        O_DP, dp5;
  logic [2:0]  O_IDX, idx5;
  logic        O_FRAME, frame5;

  seg7_scan_driver #(
    .NUM_DIG (8),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .I_CLK (I_CLK), .rst_n (rst_n),
    .I_SCAN (I_SCAN), .I_DATA (I_DATA),
    .I_DP (I_DP), .I_DIG_EN (I_DIG_EN),
    .I_LOAD (I_LOAD), .O_AN (O_AN),
    .O_SEG (O_SEG), .O_DP (O_DP),
    .O_IDX (O_IDX), .O_FRAME (O_FRAME)
  );

  seg7_scan_driver #(
    .NUM_DIG (5),
    .BLANK_CYC (BLANK_CYC)
  ) dut5 (
    .I_CLK (I_CLK), .rst_n (rst_n),
    .I_SCAN (I_SCAN), .I_DATA (I_DATA),
    .I_DP (I_DP), .I_DIG_EN (I_DIG_EN),
    .I_LOAD (I_LOAD), .O_AN (an5),
    .O_SEG (seg5), .O_DP (dp5),
    .O_IDX (idx5), .O_FRAME (frame5)
  );

  always #5 I_CLK = ~I_CLK;

  int cyc = 0;
  always @(posedge I_CLK) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         stamp;
    logic [2:0] idx;
    logic [2:0] idx5;
    logic       fr;
    logic       fr5;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } item_t;

  item_t q[$];
  bit    busy = 1'b0;
  int    ntests = 0;
  int    nfail = 0;

  logic [6:0] hexlut [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [31:0] p_data = '0, a_data = '0;
  logic [7:0]  p_en = '0, p_dp = '0;
  logic [7:0]  a_en = '0, a_dp = '0;
  int          m_idx = 0, m_idx5 = 0;
  bit          started = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge I_CLK);
    if (cyc != t) begin
      ntests++;
      nfail++;
      $display("FAIL late_check: cyc %0d want %0d",
               cyc, t);
    end
  endtask

  // Monitor: pops expectations and checks DUT outputs
  initial begin : mon
    item_t it;
    bit    ok;
    @(negedge I_CLK);
    forever begin
      while (q.size() == 0) @(negedge I_CLK);
      it = q.pop_front();
      busy = 1'b1;
      if (it.kind == 1) begin
        wait_cyc(it.stamp + 1);
        chk("rst_an", O_AN, 8'hFF);
        chk("rst_seg", O_SEG, 7'h7F);
        chk("rst_dp", O_DP, 1'b1);
        chk("rst_idx", O_IDX, 3'd0);
        chk("rst_frame", O_FRAME, 1'b0);
        chk("rst_idx5", idx5, 3'd0);
        chk("rst_seg5", seg5, 7'h7F);
        chk("rst_dp5", dp5, 1'b1);
        wait_cyc(it.stamp + 8);
        chk("hold_an", O_AN, 8'hFF);
        chk("hold_seg", O_SEG, 7'h7F);
        chk("hold_dp", O_DP, 1'b1);
        chk("hold_idx", O_IDX, 3'd0);
        chk("hold_frame", O_FRAME, 1'b0);
      end else begin
        wait_cyc(it.stamp + 3);
        chk("adv_idx", O_IDX, it.idx);
        chk("adv_frame", O_FRAME, it.fr);
        chk("adv_an", O_AN, 8'hFF);
        chk("adv_idx5", idx5, it.idx5);
        chk("adv_frame5", frame5, it.fr5);
        chk("adv_an5", an5, 8'hFF);
        ok = 1'b1;
        for (int i = 0; i < BLANK_CYC - 1; i++) begin
          @(negedge I_CLK);
          if (O_AN !== 8'hFF || O_FRAME !== 1'b0)
            ok = 1'b0;
        end
        chk("blank_hold", ok, 1'b1);
        @(negedge I_CLK);
        chk("drv_an", O_AN, it.an);
        chk("drv_seg", O_SEG, it.seg);
        chk("drv_dp", O_DP, it.dp);
        chk("drv_frame", O_FRAME, 1'b0);
        chk("drv_frame5", frame5, 1'b0);
      end
      busy = 1'b0;
    end
  end

  task automatic do_reset();
    item_t it;
    @(posedge I_CLK); #1;
    it = '{default: 0};
    it.kind = 1;
    it.stamp = cyc;
    rst_n = 1'b0;
    I_SCAN = 1'b0;
    q.push_back(it);
    repeat (3) @(posedge I_CLK);
    #1;
    rst_n = 1'b1;
    started = 1'b0;
    m_idx = 0;
    m_idx5 = 0;
    p_data = '0; p_en = '0; p_dp = '0;
    a_data = '0; a_en = '0; a_dp = '0;
    repeat (12) @(posedge I_CLK);
  endtask

  task automatic do_load(input logic [31:0] d,
                         input logic [7:0] en,
                         input logic [7:0] dp);
    @(posedge I_CLK); #1;
    I_DATA = d; I_DIG_EN = en; I_DP = dp;
    I_LOAD = 1'b1;
    p_data = d; p_en = en; p_dp = dp;
    @(posedge I_CLK); #1;
    I_LOAD = 1'b0;
  endtask

  // One scan period of 20 cycles; optional load on
  // the rise-detect cycle and optional glitch re-rise.
  task automatic scan(input bit ld,
                      input logic [31:0] d,
                      input logic [7:0] en,
                      input logic [7:0] dp,
                      input bit dbl);
    item_t it;
    @(posedge I_CLK); #1;
    it = '{default: 0};
    it.stamp = cyc;
    I_SCAN = 1'b1;
    if (ld) begin
      p_data = d; p_en = en; p_dp = dp;
    end
    if (!started) begin
      started = 1'b1;
      m_idx = 0; m_idx5 = 0;
      a_data = p_data; a_en = p_en; a_dp = p_dp;
      it.fr = 1'b0; it.fr5 = 1'b0;
    end else begin
      m_idx = (m_idx == 7) ? 0 : m_idx + 1;
      m_idx5 = (m_idx5 == 4) ? 0 : m_idx5 + 1;
      it.fr = (m_idx == 0);
      it.fr5 = (m_idx5 == 0);
      if (it.fr) begin
        a_data = p_data; a_en = p_en; a_dp = p_dp;
      end
    end
    it.idx = 3'(m_idx);
    it.idx5 = 3'(m_idx5);
    if (a_en[m_idx]) begin
      it.an = 8'(~(8'h01 << m_idx));
      it.seg = hexlut[a_data[m_idx*4 +: 4]];
      it.dp = ~a_dp[m_idx];
    end else begin
      it.an = 8'hFF;
      it.seg = 7'h7F;
      it.dp = 1'b1;
    end
    q.push_back(it);
    @(posedge I_CLK); #1;
    @(posedge I_CLK); #1;
    if (ld) begin
      I_DATA = d; I_DIG_EN = en; I_DP = dp;
      I_LOAD = 1'b1;
    end
    if (dbl) I_SCAN = 1'b0;
    @(posedge I_CLK); #1;
    I_LOAD = 1'b0;
    @(posedge I_CLK); #1;
    if (dbl) I_SCAN = 1'b1;
    repeat (6) @(posedge I_CLK);
    #1;
    I_SCAN = 1'b0;
    repeat (9) @(posedge I_CLK);
  endtask

  task automatic tick();
    scan(1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin : stim
    int guard;
    do_reset();
    do_load(32'h76543210, 8'hFF, 8'h00);
    repeat (9) tick();
    repeat (3) tick();
    do_load(32'hFFFFFFFF, 8'hFF, 8'h10);
    repeat (5) tick();
    repeat (4) tick();
    do_load(32'h0BAD0BAD, 8'h00, 8'hFF);
    do_load(32'h76543210, 8'hFB, 8'h04);
    repeat (4) tick();
    repeat (3) tick();
    scan(1'b0, '0, '0, '0, 1'b1);
    repeat (3) tick();
    scan(1'b1, 32'h000000C5, 8'hFF, 8'h01, 1'b0);
    tick();
    do_reset();
    tick();
    guard = 0;
    while ((q.size() != 0 || busy) && guard < 200) begin
      @(negedge I_CLK);
      guard++;
    end
    if (guard >= 200) begin
      ntests++;
      nfail++;
      $display("FAIL drain: %0d items left", q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
